// File: rtl/mpg_pkg.sv
// mpg_pkg
//   Shared definitions for the multi-channel pulse generator:
//   edge-select mode codes, the per-channel repeat FSM encoding, and
//   elaboration-time helpers used to size the channel counters.
package mpg_pkg;

    localparam logic [1:0] MODE_RISE = 2'b00;
    localparam logic [1:0] MODE_FALL = 2'b01;
    localparam logic [1:0] MODE_BOTH = 2'b10;
    localparam logic [1:0] MODE_RPT  = 2'b11;

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'b00,
        RPT_HOLD   = 2'b01,
        RPT_REPEAT = 2'b10
    } rpt_state_t;

    function automatic int mpg_clog2(input int value);
        int width;
        int v;
        width = 0;
        v     = value - 1;
        while (v > 0) begin
            width = width + 1;
            v     = v >> 1;
        end
        return (width < 1) ? 1 : width;
    endfunction

    function automatic int mpg_max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/mpg_chan.sv
// mpg_chan
//   One channel of the pulse generator: 2-flop synchroniser, counting
//   debouncer, edge selection and an auto-repeat FSM, with registered
//   pulse and level outputs.
//
//   state      | meaning
//   -----------+---------------------------------------------------------
//   RPT_IDLE   | no repeat activity; waiting for a debounced rise in mode 11
//   RPT_HOLD   | input held; counting HOLD_CYC cycles to the first repeat
//   RPT_REPEAT | emitting a pulse every REP_CYC cycles while still held
//
// Ports
//   clk       system clock
//   rst       asynchronous active-high reset
//   en        pulse enable (debounce keeps running while low)
//   mode      edge select, see mpg_pkg MODE_* codes
//   in_trig   raw asynchronous input
//   out_pulse registered single-cycle pulse
//   level     registered debounced level
module mpg_chan
    import mpg_pkg::*;
#(
    parameter int DB_CYC   = 4,
    parameter int HOLD_CYC = 10,
    parameter int REP_CYC  = 3,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] mode,
    input  logic       in_trig,
    output logic       out_pulse,
    output logic       level
);

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REP_CYC - 1);

    logic             s1, s2;
    logic             level_q;
    logic [1:0]       mode_q;
    logic [CNT_W-1:0] db_cnt, db_cnt_nxt;
    logic             level_nxt;
    logic [CNT_W-1:0] rep_cnt, rep_cnt_nxt;
    rpt_state_t       state, state_nxt;
    logic             rise, fall, edge_hit, rpt_pulse, pulse_nxt;

    // Mode is registered so a write only affects events computed after
    // the edge that captures it; an event already in flight uses the old mode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1        <= 1'b0;
            s2        <= 1'b0;
            level     <= 1'b0;
            level_q   <= 1'b0;
            db_cnt    <= '0;
            mode_q    <= MODE_RISE;
            state     <= RPT_IDLE;
            rep_cnt   <= '0;
            out_pulse <= 1'b0;
        end else begin
            s1        <= in_trig;
            s2        <= s1;
            level     <= level_nxt;
            level_q   <= level;
            db_cnt    <= db_cnt_nxt;
            mode_q    <= mode;
            state     <= state_nxt;
            rep_cnt   <= rep_cnt_nxt;
            out_pulse <= pulse_nxt;
        end
    end

    // Debounce: a new level is accepted only after DB_CYC consecutive
    // differing samples; any return to the current level restarts the count.
    always_comb begin
        db_cnt_nxt = db_cnt;
        level_nxt  = level;
        if (s2 == level) begin
            db_cnt_nxt = '0;
        end else if (db_cnt == DB_LAST) begin
            level_nxt  = s2;
            db_cnt_nxt = '0;
        end else begin
            db_cnt_nxt = db_cnt + 1'b1;
        end
    end

    assign rise = level & ~level_q;
    assign fall = ~level & level_q;

    always_comb begin
        edge_hit = 1'b0;
        case (mode_q)
            MODE_RISE: edge_hit = rise;
            MODE_FALL: edge_hit = fall;
            MODE_BOTH: edge_hit = rise | fall;
            MODE_RPT:  edge_hit = rise;
            default:   edge_hit = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt   = state;
        rep_cnt_nxt = rep_cnt;
        rpt_pulse   = 1'b0;
        if (!en || (mode_q != MODE_RPT) || fall) begin
            state_nxt   = RPT_IDLE;
            rep_cnt_nxt = '0;
        end else begin
            case (state)
                RPT_IDLE: begin
                    if (rise) begin
                        state_nxt   = RPT_HOLD;
                        rep_cnt_nxt = '0;
                    end
                end
                RPT_HOLD: begin
                    if (rep_cnt == HOLD_LAST) begin
                        rpt_pulse   = 1'b1;
                        state_nxt   = RPT_REPEAT;
                        rep_cnt_nxt = '0;
                    end else begin
                        rep_cnt_nxt = rep_cnt + 1'b1;
                    end
                end
                RPT_REPEAT: begin
                    if (rep_cnt == REP_LAST) begin
                        rpt_pulse   = 1'b1;
                        rep_cnt_nxt = '0;
                    end else begin
                        rep_cnt_nxt = rep_cnt + 1'b1;
                    end
                end
                default: begin
                    state_nxt   = RPT_IDLE;
                    rep_cnt_nxt = '0;
                end
            endcase
        end
    end

    assign pulse_nxt = en & (edge_hit | rpt_pulse);

endmodule

// File: rtl/multi_pulse_gen.sv
// multi_pulse_gen
//   CH independent debounced edge-to-pulse channels sharing one mode
//   select and one enable.
//
// Ports
//   clk       system clock
//   rst       asynchronous active-high reset
//   en        global pulse enable
//   mode      edge select: 00 rise, 01 fall, 10 both, 11 rise + auto-repeat
//   in_trig   raw inputs, bit i = channel i
//   out_pulse registered one-cycle pulses
//   level     registered debounced levels
module multi_pulse_gen
    import mpg_pkg::*;
#(
    parameter int CH       = 4,
    parameter int DB_CYC   = 4,
    parameter int HOLD_CYC = 10,
    parameter int REP_CYC  = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [1:0]    mode,
    input  logic [CH-1:0] in_trig,
    output logic [CH-1:0] out_pulse,
    output logic [CH-1:0] level
);

    localparam int CNT_W = mpg_clog2(mpg_max3(DB_CYC, HOLD_CYC, REP_CYC) + 1);

    for (genvar i = 0; i < CH; i++) begin : g_chan
        mpg_chan #(
            .DB_CYC   (DB_CYC),
            .HOLD_CYC (HOLD_CYC),
            .REP_CYC  (REP_CYC),
            .CNT_W    (CNT_W)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .en        (en),
            .mode      (mode),
            .in_trig   (in_trig[i]),
            .out_pulse (out_pulse[i]),
            .level     (level[i])
        );
    end

endmodule

// File: tb/tb_multi_pulse_gen.sv
module tb_multi_pulse_gen;
    import mpg_pkg::*;

    logic       clk;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic [3:0] in_trig;
    logic [3:0] out_pulse;
    logic [3:0] level;

    int checks   = 0;
    int failures = 0;

    int pidx[$];
    int lvl_idx;
    logic lvl_seen;
    logic [3:0] any_pulse;

    multi_pulse_gen #(
        .CH(4), .DB_CYC(4), .HOLD_CYC(10), .REP_CYC(3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .mode      (mode),
        .in_trig   (in_trig),
        .out_pulse (out_pulse),
        .level     (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_cap();
        pidx.delete();
        lvl_idx   = -1;
        lvl_seen  = 1'b0;
        any_pulse = 4'b0;
    endtask

    // Observations after each tick are numbered base+i, where tick 1 sits
    // just after the first clock edge following the stimulus change.
    task automatic capture(input int n, input int ch, input int base);
        for (int i = 1; i <= n; i++) begin
            tick();
            any_pulse = any_pulse | out_pulse;
            if (out_pulse[ch]) pidx.push_back(base + i);
            if (level[ch]) begin
                lvl_seen = 1'b1;
                if (lvl_idx < 0) lvl_idx = base + i;
            end
        end
    endtask

    int exp4[8] = '{7, 17, 20, 23, 26, 29, 32, 35};

    initial begin
        rst     = 1'b1;
        en      = 1'b1;
        mode    = MODE_RISE;
        in_trig = 4'b0;
        tick();
        tick();
        check("rst_pulse", 32'(out_pulse), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        rst = 1'b0;
        tick();

        // 1: single rising press on channel 0
        in_trig[0] = 1'b1;
        clear_cap();
        capture(20, 0, 0);
        check("t1_level_idx", 32'(lvl_idx), 32'd6);
        check("t1_npulse", 32'(pidx.size()), 32'd1);
        if (pidx.size() > 0) check("t1_pulse_idx", 32'(pidx[0]), 32'd7);
        in_trig[0] = 1'b0;
        clear_cap();
        capture(15, 0, 0);
        check("t1_release_nopulse", 32'(any_pulse), 32'd0);

        // 2: 3-cycle glitch on channel 1 is rejected
        in_trig[1] = 1'b1;
        clear_cap();
        capture(3, 1, 0);
        in_trig[1] = 1'b0;
        capture(15, 1, 3);
        check("t2_level", 32'(lvl_seen), 32'd0);
        check("t2_npulse", 32'(pidx.size()), 32'd0);

        // 3a: both edges on channel 2
        mode = MODE_BOTH;
        tick();
        in_trig[2] = 1'b1;
        clear_cap();
        capture(20, 2, 0);
        in_trig[2] = 1'b0;
        capture(20, 2, 20);
        check("t3b_npulse", 32'(pidx.size()), 32'd2);
        if (pidx.size() == 2) begin
            check("t3b_first", 32'(pidx[0]), 32'd7);
            check("t3b_second", 32'(pidx[1]), 32'd27);
        end

        // 3b: falling only, same stimulus
        mode = MODE_FALL;
        tick();
        in_trig[2] = 1'b1;
        clear_cap();
        capture(20, 2, 0);
        in_trig[2] = 1'b0;
        capture(20, 2, 20);
        check("t3f_npulse", 32'(pidx.size()), 32'd1);
        if (pidx.size() == 1) check("t3f_idx", 32'(pidx[0]), 32'd27);

        // 4: auto-repeat on channel 3
        mode = MODE_RPT;
        tick();
        in_trig[3] = 1'b1;
        clear_cap();
        capture(30, 3, 0);
        in_trig[3] = 1'b0;
        capture(25, 3, 30);
        check("t4_npulse", 32'(pidx.size()), 32'd8);
        for (int k = 0; k < 8; k++) begin
            if (k < pidx.size()) check($sformatf("t4_idx%0d", k), 32'(pidx[k]), 32'(exp4[k]));
        end
        check("t4_level_end", 32'(level[3]), 32'd0);

        // 5: enable low while channel 0 bounces and settles high
        mode = MODE_RISE;
        en   = 1'b0;
        tick();
        clear_cap();
        in_trig[0] = 1'b1;
        capture(2, 0, 0);
        in_trig[0] = 1'b0;
        capture(2, 0, 2);
        in_trig[0] = 1'b1;
        capture(15, 0, 4);
        en = 1'b1;
        capture(20, 0, 19);
        check("t5_npulse", 32'(any_pulse), 32'd0);
        check("t5_level", 32'(level[0]), 32'd1);

        // 6a: channels 0 and 2 pressed together
        in_trig = 4'b0;
        clear_cap();
        capture(15, 0, 0);
        in_trig = 4'b0101;
        for (int i = 0; i < 6; i++) tick();
        check("t6_pre", 32'(out_pulse), 32'd0);
        tick();
        check("t6_both", 32'(out_pulse), 32'b0101);
        tick();
        check("t6_post", 32'(out_pulse), 32'd0);
        in_trig = 4'b0;
        clear_cap();
        capture(15, 0, 0);

        // 6b: reset in the middle of channel 1 debounce
        in_trig[1] = 1'b1;
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("t6_rst_pulse", 32'(out_pulse), 32'd0);
        check("t6_rst_level", 32'(level), 32'd0);
        in_trig[1] = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        clear_cap();
        capture(20, 1, 0);
        check("t6_after_pulse", 32'(any_pulse), 32'd0);
        check("t6_after_level", 32'(lvl_seen), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multi_pulse_gen.md
Name: multi_pulse_gen

Overview:
Parametrised, multi-channel successor to the single-channel edge-to-pulse block. It synchronises and debounces CH raw inputs (push buttons, DIP switches), then emits single-clock pulses on selectable edges. An optional auto-repeat mode keeps pulsing while an input is held. It sits between board I/O pins and the FSM/counter logic of each lab top level.

Parameters:
CH, 4, number of independent channels
DB_CYC, 4, consecutive stable cycles required to accept a new level (>=1)
HOLD_CYC, 10, cycles a debounced high must persist before the first auto-repeat pulse (>=1)
REP_CYC, 3, period in cycles between auto-repeat pulses after the first (>=1)
CNT_W, derived, clog2(max(DB_CYC,HOLD_CYC,REP_CYC)+1); localparam, not overridable

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
en  input  1  global pulse enable
mode  input  2  edge select shared by all channels: 00 rising, 01 falling, 10 both, 11 rising + auto-repeat
in_trig  input  CH  raw asynchronous inputs, bit i = channel i
out_pulse  output  CH  registered one-cycle pulses
level  output  CH  registered debounced level

Behaviour:
- Interface is fixed: one clock `clk`; reset `rst` is asynchronous and active-high. While rst=1, every flop is 0: sync stages, debounced level, counters, repeat FSM, out_pulse and level.
- Synchroniser: 2 flops per channel, s1<=in_trig[i], s2<=s1.
- Debounce: if s2==level[i], clear db_cnt. Otherwise increment db_cnt. On the cycle db_cnt reaches DB_CYC-1 and s2 still differs, set level[i]<=s2 and clear db_cnt. Any glitch back to level[i] clears the count.
- Latency: in_trig changes before edge E0 and stays stable. level updates at edge E0+DB_CYC+1. out_pulse rises at edge E0+DB_CYC+2 and lasts exactly one cycle.
- Edge event (combinational, then registered into out_pulse): rise = level toggling 0->1; fall = level toggling 1->0. mode 00/11 uses rise; 01 uses fall; 10 uses rise|fall.
- Repeat FSM per channel (active only in mode 11): IDLE -> HOLD on rise, with rep_cnt cleared.
  - HOLD: rep_cnt counts. At HOLD_CYC-1, pulse and go to REPEAT, with rep_cnt cleared.
  - REPEAT: pulse each time rep_cnt reaches REP_CYC-1, then clear.
  - Any fall, mode change, or en=0 returns the FSM to IDLE with rep_cnt cleared.
- en=0: out_pulse forced 0 on next edge. Synchroniser and debounce keep tracking, so re-enabling never produces a stale pulse for an edge that happened while disabled.
- Mode change takes effect on the following edge. An edge event coincident with a mode write uses the old mode.
- Simultaneous events on different channels are independent; several out_pulse bits may be high in the same cycle.
- An input already high when reset releases: level is 0, so a rising pulse is produced after debounce. This is intended power-on behaviour.
- Reset mid-debounce or mid-repeat: all state is cleared immediately, and no pulse is emitted at or after reset release until a new debounced edge occurs.
- Counters saturate-free: cleared before wrap by construction. CNT_W guarantees no overflow.

Decomposition:
- Package mpg_pkg: mode constants MODE_RISE=2'b00, MODE_FALL=2'b01, MODE_BOTH=2'b10, MODE_RPT=2'b11; repeat FSM state encoding (IDLE, HOLD, REPEAT); clog2 function.
- Sub-module mpg_chan: one channel (synchroniser, debounce, edge select, repeat FSM, output flops).
- Top multi_pulse_gen: generate-loop of CH instances of mpg_chan, plus fan-out of mode and en.

Test Plan:
1. rst pulse, mode=00, in_trig[0] 0->1 held -> level[0]=1 at DB_CYC+1 (5) edges later; out_pulse[0] high exactly 1 cycle at edge 6; no further pulses.
2. mode=00, in_trig[1] glitch high for 3 cycles (<DB_CYC=4) -> level[1] and out_pulse[1] stay 0 throughout.
3. mode=10, in_trig[2] high for 20 cycles then low -> exactly two pulses, 20 cycles apart; mode=01 same stimulus -> only the release pulse.
4. mode=11, in_trig[3] held 30 cycles -> first pulse at press; next at +10 (HOLD_CYC); then every 3 cycles until release; zero pulses after level falls.
5. en=0 while in_trig[0] toggles and settles high, then en=1 -> no out_pulse at any time; level[0]=1.
6. Channels 0 and 2 pressed on the same cycle, and rst asserted mid-debounce on channel 1 -> out_pulse=4'b0101 in one cycle; channel 1 all zero immediately on rst and no pulse after release.
